// File: rtl/controle_rodada_pkg.sv
// rtl/controle_rodada_pkg.sv - shared state codes and button index helper for the turn sequencer
package controle_rodada_pkg;

  typedef enum logic [3:0] {
    INICIAL      = 4'h0,
    PREPARA      = 4'h1,
    ESPERA_MACRO = 4'h2,
    REG_MACRO    = 4'h3,
    ESPERA_MICRO = 4'h4,
    REG_MICRO    = 4'h5,
    ESCREVE      = 4'h6,
    VERIFICA     = 4'h7,
    ATUALIZA     = 4'h8,
    TROCA        = 4'h9,
    FIM          = 4'hA
  } estado_t;

  localparam logic [3:0] POS_NENHUMA = 4'hF;

  // Index 0..8 of the single set bit; POS_NENHUMA when zero or several bits are set.
  function automatic logic [3:0] one_hot_para_indice(input logic [8:0] v);
    logic [3:0]  idx;
    int unsigned n;
    idx = POS_NENHUMA;
    n   = 0;
    for (int i = 0; i < 9; i++) begin
      if (v[i]) begin
        idx = 4'(i);
        n   = n + 1;
      end
    end
    if (n != 1) idx = POS_NENHUMA;
    return idx;
  endfunction

endpackage

// File: rtl/controle_rodada_if.sv
// rtl/controle_rodada_if.sv - strobes and status exchanged between the turn sequencer and the game datapath
interface controle_rodada_if;
  import controle_rodada_pkg::*;

  logic [8:0] ocupado;
  logic       proxima_livre;
  logic       venceu_micro;
  logic       fim_jogo;
  logic [3:0] posicao;
  logic       registra_macro;
  logic       registra_micro;
  logic       sinal_macro;
  logic       we_board;
  logic       we_board_state;
  logic       troca_jogador;

  modport master (
    input  ocupado, proxima_livre, venceu_micro, fim_jogo,
    output posicao, registra_macro, registra_micro, sinal_macro,
           we_board, we_board_state, troca_jogador
  );

  modport slave (
    output ocupado, proxima_livre, venceu_micro, fim_jogo,
    input  posicao, registra_macro, registra_micro, sinal_macro,
           we_board, we_board_state, troca_jogador
  );
endinterface

// File: rtl/controle_rodada_detector_jogada.sv
// rtl/controle_rodada_detector_jogada.sv - rising-edge detector accepting only single-button presses
module detector_jogada
  import controle_rodada_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [8:0] botoes,
  output logic       jogada,
  output logic [3:0] indice
);

  logic [8:0] botoes_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) botoes_q <= '0;
    else        botoes_q <= botoes;
  end

  always_comb begin
    indice = one_hot_para_indice(botoes & ~botoes_q);
    jogada = (indice != POS_NENHUMA);
  end

endmodule

// File: rtl/controle_rodada.sv
// rtl/controle_rodada.sv - turn sequencer: macro/micro selection, datapath strobes, per-turn timeout
module controle_rodada
  import controle_rodada_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = 5000
)
(
  input  logic                clock,
  input  logic                reset,
  input  logic                iniciar,
  input  logic [8:0]          botoes,
  controle_rodada_if.master   bus,
  output logic                jogar_macro,
  output logic                jogar_micro,
  output logic                erro_jogada,
  output logic                timeout,
  output logic                pronto,
  output logic [3:0]          db_estado
);

  localparam int CONT_W = $clog2(TIMEOUT_CICLOS + 1);
  localparam logic [CONT_W-1:0] LIMITE = CONT_W'(TIMEOUT_CICLOS - 1);

  estado_t           estado, estado_prox;
  logic [CONT_W-1:0] timer;
  logic [3:0]        posicao_q;
  logic              perdeu_vez;
  logic              jogada;
  logic [3:0]        indice;
  logic              limpa, conta, carrega;
  logic              registra_macro, registra_micro, sinal_macro;
  logic              we_board, we_board_state, troca_jogador;

  detector_jogada u_detector (
    .clock  (clock),
    .reset  (reset),
    .botoes (botoes),
    .jogada (jogada),
    .indice (indice)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= INICIAL;
    else        estado <= estado_prox;
  end

  // Timer saturates at LIMITE so a rejected press on the expiry cycle still times out next cycle.
  // perdeu_vez marks a forfeited turn: the micro register is stale, so TROCA must not force a board.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      timer      <= '0;
      posicao_q  <= POS_NENHUMA;
      perdeu_vez <= 1'b0;
    end else begin
      if (limpa)                        timer <= '0;
      else if (conta && timer != LIMITE) timer <= timer + 1'b1;
      if (carrega)                      posicao_q <= indice;
      if (estado == TROCA)              perdeu_vez <= 1'b0;
      else if (timeout)                 perdeu_vez <= 1'b1;
    end
  end

  always_comb begin
    estado_prox    = estado;
    limpa          = 1'b0;
    conta          = 1'b0;
    carrega        = 1'b0;
    registra_macro = 1'b0;
    registra_micro = 1'b0;
    sinal_macro    = 1'b0;
    we_board       = 1'b0;
    we_board_state = 1'b0;
    troca_jogador  = 1'b0;
    jogar_macro    = 1'b0;
    jogar_micro    = 1'b0;
    erro_jogada    = 1'b0;
    timeout        = 1'b0;
    pronto         = 1'b0;
    case (estado)
      INICIAL: if (iniciar) estado_prox = PREPARA;
      PREPARA: begin
        limpa       = 1'b1;
        estado_prox = ESPERA_MACRO;
      end
      ESPERA_MACRO, ESPERA_MICRO: begin
        jogar_macro = (estado == ESPERA_MACRO);
        jogar_micro = (estado == ESPERA_MICRO);
        conta       = 1'b1;
        // A press in the expiry cycle takes priority over the timeout.
        if (jogada) begin
          if (bus.ocupado[indice]) begin
            erro_jogada = 1'b1;
          end else begin
            carrega     = 1'b1;
            estado_prox = (estado == ESPERA_MACRO) ? REG_MACRO : REG_MICRO;
          end
        end else if (timer == LIMITE) begin
          timeout     = 1'b1;
          estado_prox = TROCA;
        end
      end
      REG_MACRO: begin
        registra_macro = 1'b1;
        limpa          = 1'b1;
        estado_prox    = ESPERA_MICRO;
      end
      REG_MICRO: begin
        registra_micro = 1'b1;
        estado_prox    = ESCREVE;
      end
      ESCREVE: begin
        we_board    = 1'b1;
        estado_prox = VERIFICA;
      end
      VERIFICA: begin
        if (bus.venceu_micro)  estado_prox = ATUALIZA;
        else if (bus.fim_jogo) estado_prox = FIM;
        else                   estado_prox = TROCA;
      end
      ATUALIZA: begin
        we_board_state = 1'b1;
        estado_prox    = bus.fim_jogo ? FIM : TROCA;
      end
      TROCA: begin
        troca_jogador = 1'b1;
        limpa         = 1'b1;
        if (bus.proxima_livre) begin
          estado_prox = ESPERA_MACRO;
        end else begin
          sinal_macro = !perdeu_vez;
          estado_prox = ESPERA_MICRO;
        end
      end
      FIM: begin
        pronto = 1'b1;
        if (iniciar) estado_prox = PREPARA;
      end
      default: estado_prox = INICIAL;
    endcase
  end

  assign db_estado          = estado;
  assign bus.posicao        = posicao_q;
  assign bus.registra_macro = registra_macro;
  assign bus.registra_micro = registra_micro;
  assign bus.sinal_macro    = sinal_macro;
  assign bus.we_board       = we_board;
  assign bus.we_board_state = we_board_state;
  assign bus.troca_jogador  = troca_jogador;

endmodule
